alu_multiword_seq: RTL

Sequencer that runs wide operations (N*WORDS bits) on one shared N-bit ALU (the team's ALU_Nbit), one word per clock, least-significant word first. Carry/borrow is chained between words. The ALU is instantiated in the parent; this block drives its ports and samples its combinational outputs. Requests and responses use valid/ready handshakes, so a CPU-side master or a test harness can issue operands at any width multiple of N.

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/ALU_Nbit.sv | 37 +++
 rtl/alu_multiword_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-word ALU sequencer: opcodes, FSM states
// and the request-to-ALU opcode mapping.
package alu_seq_pkg;

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_XOR = 3'b100;
  localparam logic [2:0] MODE_NOT = 3'b101;
  localparam logic [2:0] MODE_INC = 3'b110;
  localparam logic [2:0] MODE_DEC = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // inc/dec ride on add/sub with B forced to zero and an initial carry of 1
  function automatic logic [2:0] alu_issue_mode(input logic [2:0] mode);
    case (mode)
      MODE_INC: return MODE_ADD;
      MODE_DEC: return MODE_SUB;
      default:  return mode;
    endcase
  endfunction

  function automatic logic is_arith(input logic [2:0] mode);
    return mode inside {MODE_ADD, MODE_SUB, MODE_INC, MODE_DEC};
  endfunction

  function automatic logic uses_b(input logic [2:0] mode);
    return !(mode inside {MODE_NOT, MODE_INC, MODE_DEC});
  endfunction

  function automatic logic init_carry(input logic [2:0] mode, input logic cb_in);
    if (mode inside {MODE_ADD, MODE_SUB}) return cb_in;
    if (mode inside {MODE_INC, MODE_DEC}) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/ALU_Nbit.sv
// N-bit combinational ALU shared by the multi-word sequencer; CB_out is the
// carry for add/inc and the borrow for sub/dec.
module ALU_Nbit
  import alu_seq_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2:0]   mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CB_in,
  output logic [N-1:0] res,
  output logic         CB_out
);

  logic [N:0] wide;

  // The extra MSB of the N+1-bit difference is set exactly when it went negative.
  always_comb begin
    wide   = '0;
    res    = '0;
    CB_out = 1'b0;
    case (mode)
      MODE_ADD: wide = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, CB_in};
      MODE_SUB: wide = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, CB_in};
      MODE_INC: wide = {1'b0, A} + {{N{1'b0}}, 1'b1};
      MODE_DEC: wide = {1'b0, A} - {{N{1'b0}}, 1'b1};
      MODE_AND: wide = {1'b0, A & B};
      MODE_OR:  wide = {1'b0, A | B};
      MODE_XOR: wide = {1'b0, A ^ B};
      default:  wide = {1'b0, ~A};
    endcase
    res    = wide[N-1:0];
    CB_out = is_arith(mode) & wide[N];
  end

endmodule

// File: rtl/alu_multiword_seq.sv
// Runs N*WORDS-bit operations on an external N-bit ALU, one word per clock,
// LSW first, with carry/borrow chained. Optional rsp_zero: ALU_SEQ_ZERO_FLAG_EN.
module alu_multiword_seq
  import alu_seq_pkg::*;
#(
  parameter int N     = 3,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_mode,
  input  logic [N*WORDS-1:0] req_a,
  input  logic [N*WORDS-1:0] req_b,
  input  logic               req_cb_in,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N*WORDS-1:0] rsp_res,
  output logic               rsp_cb_out,
  output logic [2:0]         alu_mode,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic               alu_cb_in,
  input  logic [N-1:0]       alu_res,
  input  logic               alu_cb_out
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic               rsp_zero
`endif
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [2:0]       mode_q;
  logic [W-1:0]     a_q, b_q, res_next;
  logic             cb_q;
  logic             last_word;
  logic             cb_next;

  assign last_word = (idx == LAST_IDX);
  assign cb_next   = is_arith(mode_q) & alu_cb_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = S_EXEC;
      S_EXEC:  if (last_word) state_next = S_DONE;
      S_DONE:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_mode  = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cb_in = 1'b0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_EXEC: begin
        alu_mode  = alu_issue_mode(mode_q);
        alu_a     = a_q[int'(idx)*N +: N];
        alu_b     = b_q[int'(idx)*N +: N];
        alu_cb_in = cb_q;
      end
      S_DONE:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Full result with the current word merged in, so the zero flag sees all W bits.
  always_comb begin
    res_next = rsp_res;
    res_next[int'(idx)*N +: N] = alu_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      mode_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cb_q       <= 1'b0;
      rsp_res    <= '0;
      rsp_cb_out <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      rsp_zero   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          mode_q <= req_mode;
          a_q    <= req_a;
          b_q    <= uses_b(req_mode) ? req_b : '0;
          cb_q   <= init_carry(req_mode, req_cb_in);
          idx    <= '0;
        end
        S_EXEC: begin
          rsp_res <= res_next;
          cb_q    <= cb_next;
          if (last_word) begin
            rsp_cb_out <= cb_next;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            rsp_zero   <= (res_next == '0);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
